// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues synchronous word reads to BIOS/IMEM and
// presents inst_o/pc_o to decode over a valid/ready handshake, with redirect and fault handling.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter int unsigned IMEM_AW  = 14,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ready_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_addr_i,
    output logic [IMEM_AW-1:0] bios_addr_o,
    output logic               bios_en_o,
    input  logic [31:0]        bios_rdata_i,
    output logic [IMEM_AW-1:0] imem_addr_o,
    output logic               imem_en_o,
    input  logic [31:0]        imem_rdata_i,
    output logic               valid_o,
    output logic [31:0]        inst_o,
    output logic [31:0]        pc_o,
    output logic               fault_o,
    output logic [31:0]        fetch_cnt_o
);

    typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
    typedef enum logic [1:0] {REG_NONE, REG_BIOS, REG_IMEM} region_t;

    state_t      r_state;
    region_t     r_region;
    logic [31:0] r_req_pc;
    logic        r_fault;
    logic [31:0] r_cnt;

    state_t      w_next_state;
    region_t     w_region;
    logic [31:0] w_next_pc;
    logic [31:0] w_redir_pc;
    logic        w_issue;
    logic        w_accept;

    function automatic region_t f_region(input logic [31:0] pc);
        case (pc[31:28])
            4'h4:    f_region = REG_BIOS;
            4'h1:    f_region = REG_IMEM;
            default: f_region = REG_NONE;
        endcase
    endfunction

    // r_req_pc is the address whose data arrives this cycle, hence also pc_o outside BOOT
    assign valid_o     = (r_state != BOOT);
    assign pc_o        = valid_o ? r_req_pc : '0;
    assign fault_o     = r_fault;
    assign fetch_cnt_o = r_cnt;
    assign w_accept    = valid_o & ready_i & ~redirect_i;
    assign w_redir_pc  = redirect_addr_i & ~32'd3;

    always_comb begin
        w_next_pc = r_req_pc;
        w_issue   = 1'b1;
        case (r_state)
            BOOT: w_next_pc = r_req_pc;
            RUN: begin
                if (redirect_i)    w_next_pc = w_redir_pc;
                else if (!ready_i) w_next_pc = r_req_pc;
                else               w_next_pc = r_req_pc + 32'd4;
            end
            FAULT: begin
                if (redirect_i) w_next_pc = w_redir_pc;
                else            w_issue   = 1'b0;
            end
            default: w_issue = 1'b0;
        endcase
        w_region     = w_issue ? f_region(w_next_pc) : REG_NONE;
        // No read issued means either an unmapped target or a parked FAULT state
        w_next_state = (w_region == REG_NONE) ? FAULT : RUN;
    end

    assign bios_en_o   = rst_n & (w_region == REG_BIOS);
    assign imem_en_o   = rst_n & (w_region == REG_IMEM);
    assign bios_addr_o = w_next_pc[IMEM_AW+1:2];
    assign imem_addr_o = w_next_pc[IMEM_AW+1:2];

    always_comb begin
        case (r_region)
            REG_BIOS: inst_o = bios_rdata_i;
            REG_IMEM: inst_o = imem_rdata_i;
            default:  inst_o = NOP_INST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= BOOT;
            r_region <= REG_NONE;
            r_req_pc <= RESET_PC;
            r_fault  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_next_state;
            r_region <= w_region;
            r_req_pc <= w_next_pc;
            if (w_next_state == FAULT) r_fault <= 1'b1;
            if (w_accept)              r_cnt   <= r_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: table of per-cycle vectors plus an async-reset sequence,
// with BIOS/IMEM modelled as synchronous memories returning address-tagged words.
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready_i = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_addr_i = '0;
    logic [13:0] bios_addr_o, imem_addr_o;
    logic        bios_en_o, imem_en_o;
    logic [31:0] bios_rdata_i = '0;
    logic [31:0] imem_rdata_i = '0;
    logic        valid_o, fault_o;
    logic [31:0] inst_o, pc_o, fetch_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    if_fetch #(.RESET_PC(32'h4000_0000), .IMEM_AW(14), .NOP_INST(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .ready_i(ready_i), .redirect_i(redirect_i),
        .redirect_addr_i(redirect_addr_i),
        .bios_addr_o(bios_addr_o), .bios_en_o(bios_en_o), .bios_rdata_i(bios_rdata_i),
        .imem_addr_o(imem_addr_o), .imem_en_o(imem_en_o), .imem_rdata_i(imem_rdata_i),
        .valid_o(valid_o), .inst_o(inst_o), .pc_o(pc_o), .fault_o(fault_o),
        .fetch_cnt_o(fetch_cnt_o)
    );

    always #5 clk = ~clk;

    // BIOS word at address a is 0xB000_0000|a, IMEM word is 0xA000_0000|a
    always @(posedge clk) begin
        if (bios_en_o) bios_rdata_i <= 32'hB000_0000 | {18'd0, bios_addr_o};
        if (imem_en_o) imem_rdata_i <= 32'hA000_0000 | {18'd0, imem_addr_o};
    end

    typedef struct {
        logic        ready;
        logic        redir;
        logic [31:0] raddr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [31:0] e_cnt;
        logic        e_fault;
        logic        e_ben;
        logic        e_ien;
        logic [13:0] e_addr;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic rdy, input logic rd, input logic [31:0] ra,
                                input logic v, input logic [31:0] pc, input logic [31:0] inst,
                                input logic [31:0] cnt, input logic flt, input logic be,
                                input logic ie, input logic [13:0] a);
        vec_t t;
        t.ready = rdy; t.redir = rd; t.raddr = ra; t.e_valid = v; t.e_pc = pc;
        t.e_inst = inst; t.e_cnt = cnt; t.e_fault = flt; t.e_ben = be; t.e_ien = ie;
        t.e_addr = a;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        //            rdy rd raddr          v  pc             inst           cnt flt be ie addr
        tbl[0]  = mk(1, 0, 32'h0,          0, 32'h0,         NOP,           0, 0, 1, 0, 14'h0);
        tbl[1]  = mk(1, 0, 32'h0,          1, 32'h4000_0000, 32'hB000_0000, 0, 0, 1, 0, 14'h1);
        tbl[2]  = mk(1, 0, 32'h0,          1, 32'h4000_0004, 32'hB000_0001, 1, 0, 1, 0, 14'h2);
        tbl[3]  = mk(0, 0, 32'h0,          1, 32'h4000_0008, 32'hB000_0002, 2, 0, 1, 0, 14'h2);
        tbl[4]  = mk(0, 0, 32'h0,          1, 32'h4000_0008, 32'hB000_0002, 2, 0, 1, 0, 14'h2);
        tbl[5]  = mk(0, 0, 32'h0,          1, 32'h4000_0008, 32'hB000_0002, 2, 0, 1, 0, 14'h2);
        tbl[6]  = mk(1, 0, 32'h0,          1, 32'h4000_0008, 32'hB000_0002, 2, 0, 1, 0, 14'h3);
        tbl[7]  = mk(1, 0, 32'h0,          1, 32'h4000_000C, 32'hB000_0003, 3, 0, 1, 0, 14'h4);
        tbl[8]  = mk(1, 1, 32'h1000_0042,  1, 32'h4000_0010, 32'hB000_0004, 4, 0, 0, 1, 14'h10);
        tbl[9]  = mk(0, 0, 32'h0,          1, 32'h1000_0040, 32'hA000_0010, 4, 0, 0, 1, 14'h10);
        tbl[10] = mk(0, 1, 32'h4000_0100,  1, 32'h1000_0040, 32'hA000_0010, 4, 0, 1, 0, 14'h40);
        tbl[11] = mk(1, 0, 32'h0,          1, 32'h4000_0100, 32'hB000_0040, 4, 0, 1, 0, 14'h41);
        tbl[12] = mk(1, 1, 32'h2000_0000,  1, 32'h4000_0104, 32'hB000_0041, 5, 0, 0, 0, 14'h0);
        tbl[13] = mk(0, 0, 32'h0,          1, 32'h2000_0000, NOP,           5, 1, 0, 0, 14'h0);
        tbl[14] = mk(0, 0, 32'h0,          1, 32'h2000_0000, NOP,           5, 1, 0, 0, 14'h0);
        tbl[15] = mk(0, 1, 32'h4000_0000,  1, 32'h2000_0000, NOP,           5, 1, 1, 0, 14'h0);
        tbl[16] = mk(1, 0, 32'h0,          1, 32'h4000_0000, 32'hB000_0000, 5, 1, 1, 0, 14'h1);
        tbl[17] = mk(1, 0, 32'h0,          1, 32'h4000_0004, 32'hB000_0001, 6, 1, 1, 0, 14'h2);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            ready_i = tbl[i].ready;
            redirect_i = tbl[i].redir;
            redirect_addr_i = tbl[i].raddr;
            #1;
            chk($sformatf("row%0d valid", i), {31'd0, valid_o}, {31'd0, tbl[i].e_valid});
            chk($sformatf("row%0d fault", i), {31'd0, fault_o}, {31'd0, tbl[i].e_fault});
            chk($sformatf("row%0d cnt", i), fetch_cnt_o, tbl[i].e_cnt);
            chk($sformatf("row%0d bios_en", i), {31'd0, bios_en_o}, {31'd0, tbl[i].e_ben});
            chk($sformatf("row%0d imem_en", i), {31'd0, imem_en_o}, {31'd0, tbl[i].e_ien});
            if (tbl[i].e_valid) begin
                chk($sformatf("row%0d pc", i), pc_o, tbl[i].e_pc);
                chk($sformatf("row%0d inst", i), inst_o, tbl[i].e_inst);
            end else begin
                chk($sformatf("row%0d pc_idle", i), pc_o, 32'h0);
            end
            if (tbl[i].e_ben)
                chk($sformatf("row%0d bios_addr", i), {18'd0, bios_addr_o}, {18'd0, tbl[i].e_addr});
            if (tbl[i].e_ien)
                chk($sformatf("row%0d imem_addr", i), {18'd0, imem_addr_o}, {18'd0, tbl[i].e_addr});
            @(negedge clk);
        end

        // asynchronous reset asserted between edges while stalled
        ready_i = 1'b0;
        redirect_i = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst valid", {31'd0, valid_o}, 32'd0);
        chk("arst pc", pc_o, 32'h0);
        chk("arst inst", inst_o, NOP);
        chk("arst cnt", fetch_cnt_o, 32'd0);
        chk("arst fault", {31'd0, fault_o}, 32'd0);
        chk("arst bios_en", {31'd0, bios_en_o}, 32'd0);
        chk("arst imem_en", {31'd0, imem_en_o}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        ready_i = 1'b1;
        #1;
        chk("boot valid", {31'd0, valid_o}, 32'd0);
        chk("boot bios_en", {31'd0, bios_en_o}, 32'd1);
        chk("boot bios_addr", {18'd0, bios_addr_o}, 32'd0);
        @(negedge clk);
        #1;
        chk("restart valid", {31'd0, valid_o}, 32'd1);
        chk("restart pc", pc_o, 32'h4000_0000);
        chk("restart inst", inst_o, 32'hB000_0000);
        @(negedge clk);
        #1;
        chk("restart pc2", pc_o, 32'h4000_0004);
        chk("restart cnt", fetch_cnt_o, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
